pulse_train_gen: RTL
====================

// Module: pulse_train_gen
// PURPOSE
//  Transmit side of the pulse-count interface: on a start request, emits a burst of N pulses
//  on pulse_out with programmable high and low widths, then signals completion.
//  Drives the start/count input of downstream pulse counters. Also serves as their stimulus
//  source in system tests.
// PARAMETERS
//  CNT_W     8   width of num_pulses and pulses_sent
//  PERIOD_W  8   width of high_cyc / low_cyc phase-length fields
// PORTS
//  clk          in   1         clock, all logic on posedge
//  rst          in   1         asynchronous, active-high reset
//  start        in   1         request burst; accepted only in IDLE
//  abort        in   1         terminate burst in progress
//  num_pulses   in   CNT_W     pulses in burst, sampled on accepted start
//  high_cyc     in   PERIOD_W  cycles pulse_out is high per pulse, sampled on start
//  low_cyc      in   PERIOD_W  cycles pulse_out is low between pulses, sampled on start
//  pulse_out    out  1         registered pulse train
//  busy         out  1         burst in progress (HIGH, LOW or DONE state)
//  done         out  1         one-cycle strobe: burst completed normally
//  pulses_sent  out  CNT_W     pulses emitted in current/last burst
// BEHAVIOUR
//  - Reset: state=IDLE, pulse_out=0, busy=0, done=0, pulses_sent=0.
//  - Reset is asynchronous and may occur at any point, including mid-burst. No residue.
//  - States: IDLE, HIGH, LOW, DONE. All outputs are registered.
//  - IDLE: start=1 with abort=0 latches num_pulses, high_cyc and low_cyc, and clears pulses_sent.
//    If num_pulses==0: go to DONE; no pulse is emitted.
//    Otherwise: go to HIGH.
//  - Latency: start sampled at edge T -> pulse_out=1 and busy=1 visible after edge T+1.
//  - A high_cyc or low_cyc value of 0 is treated as 1. Phase widths are never zero.
//  - HIGH: pulse_out=1 for exactly high_cyc cycles.
//    pulses_sent increments on entry to HIGH, so it counts rising edges.
//    At the end of the phase: if pulses_sent==latched N -> DONE, else -> LOW.
//  - LOW: pulse_out=0 for exactly low_cyc cycles, then -> HIGH.
//    No trailing LOW phase after the last pulse.
//  - DONE: lasts one cycle. done=1, busy=1, pulse_out=0. Then -> IDLE (busy=0).
//  - start outside IDLE, including in DONE, is ignored. No queuing.
//  - abort in HIGH or LOW: next edge -> IDLE with pulse_out=0 and busy=0. done is NOT pulsed.
//    pulses_sent holds its partial count.
//  - abort in IDLE or DONE has no effect. However, abort=1 with start=1 in IDLE blocks the start.
//  - Phase counter width = PERIOD_W. Pulse counter width = CNT_W.
//    num_pulses = 2^CNT_W-1 is legal. No counter wraps within a burst.
//  - Example, N=3, high=2, low=1: pulse_out = 1 1 0 1 1 0 1 1, then done=1.
//    Total burst = N*high + (N-1)*low cycles, plus 1 DONE cycle.
//  - pulses_sent holds its value after done until the next accepted start.
// STRUCTURE
//  - Shared header pulse_pkg.vh holds:
//    state encodings PT_IDLE=2'd0, PT_HIGH=2'd1, PT_LOW=2'd2, PT_DONE=2'd3;
//    default widths CNT_W and PERIOD_W.
//  - One sub-module, phase_timer (PERIOD_W). It is a loadable down-counter:
//    load and len in, expire out. expire is asserted in the last cycle of the phase.
//    The 0 -> 1 clamp is applied inside phase_timer.
//  - The FSM, latched parameters and the pulses_sent counter live in the top module.
// TESTING
//  1. N=3, high=2, low=1, start for one cycle:
//     -> pulse_out 11011011 starting at T+1; done at T+9; pulses_sent=3; busy low at T+10.
//  2. N=0:
//     -> no pulse_out activity; done=1 at T+1; busy 1 for one cycle; pulses_sent=0.
//  3. N=5, high=0, low=0 (clamped):
//     -> pulse_out 101010101; done one cycle after the last high.
//  4. N=10, high=3, low=3; abort during the 4th LOW phase:
//     -> pulse_out=0 and busy=0 next cycle; done never asserted; pulses_sent=4.
//  5. N=4; start re-asserted mid-burst and during DONE:
//     -> ignored; burst unchanged.
//     Start + abort together in IDLE -> no burst.
//  6. N=20; rst asserted asynchronously mid-HIGH:
//     -> all outputs 0 immediately.
//     A new start after release runs a clean full burst.
//     Loopback into pulse_counter with N=20, high=1, low=1: op_sig fires on exactly 2 cycles.

Source files
------------

// File: rtl/pulse_train_gen_pkg.sv
// Shared types and default widths for the pulse train generator.
package pulse_train_gen_pkg;

  typedef enum logic [1:0] {
    PT_IDLE = 2'd0,
    PT_HIGH = 2'd1,
    PT_LOW  = 2'd2,
    PT_DONE = 2'd3
  } pt_state_t;

  localparam int unsigned CNT_W_DEF    = 8;
  localparam int unsigned PERIOD_W_DEF = 8;

endpackage

// File: rtl/pulse_train_gen_phase_timer.sv
// Loadable phase down-counter; expire marks the last cycle of the loaded phase.
module phase_timer #(
  parameter int unsigned PERIOD_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [PERIOD_W-1:0] len,
  output logic                expire
);

  logic [PERIOD_W-1:0] cnt;

  // A zero length behaves like a length of one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= (len == '0) ? '0 : len - PERIOD_W'(1);
    else if (cnt != '0)
      cnt <= cnt - PERIOD_W'(1);
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Burst pulse generator: N pulses with programmable high/low widths, then a done strobe.
module pulse_train_gen
  import pulse_train_gen_pkg::*;
#(
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned PERIOD_W = PERIOD_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [CNT_W-1:0]    num_pulses,
  input  logic [PERIOD_W-1:0] high_cyc,
  input  logic [PERIOD_W-1:0] low_cyc,
  output logic                pulse_out,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    pulses_sent
);

  pt_state_t           state;
  logic [CNT_W-1:0]    n_lat;
  logic [CNT_W-1:0]    cnt;
  logic [PERIOD_W-1:0] high_lat;
  logic [PERIOD_W-1:0] low_lat;
  logic                timer_load;
  logic [PERIOD_W-1:0] timer_len;
  logic                expire;

  phase_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .len    (timer_len),
    .expire (expire)
  );

  always_comb begin
    timer_load = 1'b0;
    timer_len  = high_lat;
    case (state)
      PT_IDLE: if (start && !abort && num_pulses != '0) begin
        timer_load = 1'b1;
        timer_len  = high_cyc;
      end
      PT_HIGH: if (expire && cnt != n_lat) begin
        timer_load = 1'b1;
        timer_len  = low_lat;
      end
      PT_LOW: if (expire) begin
        timer_load = 1'b1;
        timer_len  = high_lat;
      end
      default: ;
    endcase
  end

  // Outputs are registered from the current state, so they trail it by one
  // cycle; abort bypasses that pipeline to clear pulse_out/busy on the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= PT_IDLE;
      n_lat       <= '0;
      cnt         <= '0;
      high_lat    <= '0;
      low_lat     <= '0;
      pulse_out   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pulses_sent <= '0;
    end else begin
      pulse_out   <= (state == PT_HIGH);
      busy        <= (state != PT_IDLE);
      done        <= (state == PT_DONE);
      pulses_sent <= cnt;
      case (state)
        PT_IDLE: if (start && !abort) begin
          n_lat    <= num_pulses;
          high_lat <= high_cyc;
          low_lat  <= low_cyc;
          if (num_pulses == '0) begin
            cnt   <= '0;
            state <= PT_DONE;
          end else begin
            cnt   <= CNT_W'(1);
            state <= PT_HIGH;
          end
        end
        PT_HIGH, PT_LOW: begin
          if (abort) begin
            state       <= PT_IDLE;
            pulse_out   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pulses_sent <= pulses_sent;
            cnt         <= pulses_sent;
          end else if (expire) begin
            if (state == PT_LOW) begin
              cnt   <= cnt + CNT_W'(1);
              state <= PT_HIGH;
            end else if (cnt == n_lat) begin
              state <= PT_DONE;
            end else begin
              state <= PT_LOW;
            end
          end
        end
        PT_DONE: state <= PT_IDLE;
        default: state <= PT_IDLE;
      endcase
    end
  end

endmodule
